// File: rtl/shift_rows_pipe.sv
// Forward AES ShiftRows stage behind a two-entry elastic output buffer.
// Optional build macro SHIFT_ROWS_INV_EN adds an inv port selecting the inverse rotation.
module shift_rows_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
`ifdef SHIFT_ROWS_INV_EN
    input  logic             inv,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    logic [127:0]     out_q, out_d;
    logic [127:0]     skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     shifted;
    logic             in_fire;
    logic             out_fire;
    logic             inv_sel;

    // Rows are big-endian words: byte 4r sits in bits [31:24].
    function automatic logic [31:0] rotl(input logic [31:0] w,
                                         input logic [1:0]  n);
        logic [31:0] r;
        r = w;
        unique case (n)
            2'd0: r = w;
            2'd1: r = {w[23:0], w[31:24]};
            2'd2: r = {w[15:0], w[31:16]};
            2'd3: r = {w[7:0],  w[31:8]};
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef SHIFT_ROWS_INV_EN
    assign inv_sel = inv;
`else
    assign inv_sel = 1'b0;
`endif

    // Inverse rotation is the complement: rows 1 and 3 swap amounts.
    always_comb begin
        shifted = in_data;
        shifted[127:96] = in_data[127:96];
        shifted[95:64]  = rotl(in_data[95:64], inv_sel ? 2'd3 : 2'd1);
        shifted[63:32]  = rotl(in_data[63:32], 2'd2);
        shifted[31:0]   = rotl(in_data[31:0],  inv_sel ? 2'd1 : 2'd3);
    end

    assign in_ready  = (state_q != FULL) & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_q;
    assign blk_cnt   = cnt_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + CNT_W'(out_fire);
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    out_d   = shifted;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = FULL;
                    skid_d  = shifted;
                end else if (in_fire && out_fire) begin
                    out_d   = shifted;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: driver queues expected states,
// a negedge monitor pops them on each output handshake.
module tb_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         inv_drv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [15:0]  blk_cnt;
    logic         in_ready4;
    logic         out_valid4;
    logic [127:0] out_data4;
    logic [3:0]   blk_cnt4;

    logic [127:0] exp_q[$];
    logic [15:0]  cnt_m = '0;
    int           nvec  = 0;
    int           nfail = 0;
    int           stalls = 0;

    always #5 clk = ~clk;

    shift_rows_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SHIFT_ROWS_INV_EN
        .inv(inv_drv),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .blk_cnt(blk_cnt)
    );

    shift_rows_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
`ifdef SHIFT_ROWS_INV_EN
        .inv(inv_drv),
`endif
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data(out_data4), .blk_cnt(blk_cnt4)
    );

    function automatic logic [127:0] model(input logic [127:0] d, input bit iv);
        int fwd[16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};
        int bwd[16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};
        logic [127:0] o;
        int s;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            s = iv ? bwd[k] : fwd[k];
            o[127-8*k -: 8] = d[127-8*s -: 8];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push(input logic [127:0] d, input bit iv);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        inv_drv  = iv;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                n++;
                stalls++;
            end
        end
        if (ok) begin
            exp_q.push_back(model(d, iv));
            @(posedge clk);
        end else begin
            nvec++;
            nfail++;
            $display("FAIL push_timeout: in_ready stuck 0 for %0d cycles, required 1", n);
        end
        #2;
        in_valid = 1'b0;
    endtask

    // Monitor: a handshake visible at negedge completes at the next posedge.
    always @(negedge clk) begin
        logic [127:0] e;
        if (rst) begin
            exp_q.delete();
            cnt_m = '0;
        end else begin
            chk("blk_cnt", 128'(blk_cnt), 128'(cnt_m));
            chk("blk_cnt4", 128'(blk_cnt4), 128'(cnt_m[3:0]));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_out: got %h expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                    chk("out_data4", out_data4, e);
                end
                cnt_m = cnt_m + 16'd1;
            end
            if (flush) exp_q.delete();
        end
    end

    localparam logic [127:0] V1 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] A  = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] B  = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
    localparam logic [127:0] C  = 128'hA0A1A2A3B0B1B2B3C0C1C2C3D0D1D2D3;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        inv_drv = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_blk_cnt", 128'(blk_cnt), 128'd0);

        push(V1, 1'b0);
        chk("t1_valid", 128'(out_valid), 128'd1);
        chk("t1_data", out_data, 128'h00010203050607040A0B08090F0C0D0E);
        @(posedge clk);
        #2 chk("t1_cnt", 128'(blk_cnt), 128'd1);

        out_ready = 1'b0;
        push(A, 1'b0);
        push(B, 1'b0);
        #1 chk("bp_full_ready", 128'(in_ready), 128'd0);
        fork
            push(C, 1'b0);
            begin
                repeat (3) @(negedge clk);
                chk("bp_hold_ready", 128'(in_ready), 128'd0);
                chk("bp_hold_data", out_data, 128'h1122334466778855BBCC99AA00DDEEFF);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #2;
        chk("bp_cnt", 128'(blk_cnt), 128'd4);
        chk("bp_drained", 128'(out_valid), 128'd0);

        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            push({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("stream_stalls", 128'(stalls), 128'd0);
        chk("stream_cnt", 128'(blk_cnt), 128'd104);

        out_ready = 1'b0;
        push(A, 1'b0);
        push(B, 1'b0);
        in_valid = 1'b1;
        in_data  = C;
        flush    = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", 128'(out_valid), 128'd0);
        chk("flush_ready", 128'(in_ready), 128'd1);
        chk("flush_cnt", 128'(blk_cnt), 128'd104);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk("flush_idle", 128'(out_valid), 128'd0);

        out_ready = 1'b0;
        push(A, 1'b0);
        push(B, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_cnt", 128'(blk_cnt), 128'd0);
        chk("mrst_cnt4", 128'(blk_cnt4), 128'd0);
        chk("mrst_valid", 128'(out_valid), 128'd0);
        chk("mrst_data", out_data, 128'd0);
        chk("mrst_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push({4{32'(i * 32'h01010101)}}, 1'b0);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("wrap_cnt4", 128'(blk_cnt4), 128'd1);
        chk("wrap_cnt", 128'(blk_cnt), 128'd17);

`ifdef SHIFT_ROWS_INV_EN
        push(V1, 1'b1);
        chk("inv_data", out_data, 128'h00010203070405060A0B08090D0E0F0C);
        out_ready = 1'b0;
        push(A, 1'b0);
        push(B, 1'b1);
        fork
            push(C, 1'b0);
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        push(V1, 1'b1);
        repeat (4) @(posedge clk);
        #2 chk("inv_drained", 128'(out_valid), 128'd0);
`endif

        repeat (2) @(posedge clk);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
